pixel_sensor_ctrl: RTL

//  Frame sequencer sitting directly upstream of the pixel sensor array element.

---
 rtl/pixel_sensor_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pixel_sensor_ctrl.sv
// pixel_sensor_ctrl
//   Frame sequencer for a single pixel sensor element. Each accepted start
//   pulse runs ERASE -> EXPOSE -> CONVERT -> TURN -> READ -> OUTPUT. During
//   CONVERT the ramp code is driven onto the shared DATA bus. During READ the
//   pixel drives DATA, and the code is captured on the last READ cycle. The
//   captured code is then offered downstream over valid/ready.
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : frame request, honoured only in IDLE
//   busy                : high whenever not IDLE
//   erase/expose/read   : pixel strobes, one per phase
//   ramp_en             : ramp generator enable, high while codes are driven
//   data_oe, data_out   : DATA bus drive enable and ramp code (0 when not driving)
//   data_in             : DATA bus sampled value
//   pix_data, pix_valid : captured pixel code and its valid
//   pix_ready           : downstream accept
module pixel_sensor_ctrl #(
    parameter int ERASE_CYCLES   = 5,
    parameter int EXPOSE_CYCLES  = 255,
    parameter int CONVERT_CYCLES = 255,
    parameter int READ_CYCLES    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       erase,
    output logic       expose,
    output logic       ramp_en,
    output logic       read,
    output logic       data_oe,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready
);

    generate
        if (ERASE_CYCLES < 1 || ERASE_CYCLES > 65535) begin : g_bad_erase
            $error("ERASE_CYCLES out of range 1..65535");
        end
        if (EXPOSE_CYCLES < 1 || EXPOSE_CYCLES > 65535) begin : g_bad_expose
            $error("EXPOSE_CYCLES out of range 1..65535");
        end
        if (CONVERT_CYCLES < 1 || CONVERT_CYCLES > 256) begin : g_bad_convert
            $error("CONVERT_CYCLES out of range 1..256");
        end
        if (READ_CYCLES < 1 || READ_CYCLES > 65535) begin : g_bad_read
            $error("READ_CYCLES out of range 1..65535");
        end
    endgenerate

    // Counter is loaded with N-1 on entry; the state exits on the cycle it reads 0.
    localparam logic [15:0] ERASE_LD   = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] EXPOSE_LD  = 16'(EXPOSE_CYCLES - 1);
    localparam logic [15:0] CONVERT_LD = 16'(CONVERT_CYCLES - 1);
    localparam logic [15:0] READ_LD    = 16'(READ_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_TURN, S_READ, S_OUTPUT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic        last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        pix_data_d = pix_data_q;
        last       = (cnt_q == 16'd0);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ERASE;
                    cnt_d   = ERASE_LD;
                end
            end
            S_ERASE: begin
                if (last) begin
                    state_d = S_EXPOSE;
                    cnt_d   = EXPOSE_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_EXPOSE: begin
                if (last) begin
                    state_d = S_CONVERT;
                    cnt_d   = CONVERT_LD;
                    code_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_CONVERT: begin
                // The code only advances while more codes remain, so a
                // 256-step ramp ends on 8'hFF without wrapping.
                if (last) begin
                    state_d = S_TURN;
                end else begin
                    cnt_d  = cnt_q - 16'd1;
                    code_d = code_q + 8'd1;
                end
            end
            S_TURN: begin
                // One dead cycle so the ramp driver releases DATA before the pixel drives it.
                state_d = S_READ;
                cnt_d   = READ_LD;
            end
            S_READ: begin
                if (last) begin
                    state_d    = S_OUTPUT;
                    pix_data_d = data_in;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_OUTPUT: begin
                if (pix_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe is high in
    // exactly the cycles the FSM occupies the matching state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            code_q     <= 8'd0;
            pix_data_q <= 8'd0;
            busy       <= 1'b0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            ramp_en    <= 1'b0;
            read       <= 1'b0;
            data_oe    <= 1'b0;
            data_out   <= 8'd0;
            pix_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            pix_data_q <= pix_data_d;
            busy       <= (state_d != S_IDLE);
            erase      <= (state_d == S_ERASE);
            expose     <= (state_d == S_EXPOSE);
            ramp_en    <= (state_d == S_CONVERT);
            read       <= (state_d == S_READ);
            data_oe    <= (state_d == S_CONVERT);
            data_out   <= (state_d == S_CONVERT) ? code_d : 8'd0;
            pix_valid  <= (state_d == S_OUTPUT);
        end
    end

    assign pix_data = pix_data_q;

endmodule
